// File: rtl/cache_sim_pkg.sv
// Shared types and width helpers for the cache simulation engine.
// Width helpers keep the tag/index/offset split in one place.
package cache_sim_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_FILL,
        S_UPDATE,
        S_RESP
    } state_t;

    localparam int POL_LRU  = 0;
    localparam int POL_FIFO = 1;

    function automatic int log2_f(input int v);
        return $clog2(v);
    endfunction

    function automatic int way_w_f(input int way);
        return (way > 1) ? $clog2(way) : 1;
    endfunction

    function automatic int tag_w_f(input int addr_w, input int set, input int blk);
        return addr_w - $clog2(set) - $clog2(blk);
    endfunction

endpackage

// File: rtl/cache_repl_policy.sv
// Per-set replacement state: LRU age stacks or FIFO pointers.
// Picks the victim way for the addressed set and updates it on access.
module cache_repl_policy
    import cache_sim_pkg::*;
#(
    parameter int WAY    = 4,
    parameter int SET    = 16,
    parameter int POLICY = POL_LRU,
    localparam int WAY_W = way_w_f(WAY),
    localparam int IDX_W = log2_f(SET)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic [WAY-1:0]   valid_vec,
    input  logic             hit_en,
    input  logic             fill_en,
    input  logic [WAY_W-1:0] acc_way,
    output logic [WAY_W-1:0] victim
);

    if (POLICY == POL_FIFO) begin : g_fifo
        logic [WAY_W-1:0] ptr_q [SET];
        logic             unused_fifo;

        assign unused_fifo = ^{hit_en, valid_vec, acc_way};

        always_ff @(posedge clk) begin
            if (rst || flush_en) begin
                for (int s = 0; s < SET; s++) ptr_q[s] <= '0;
            end else if (fill_en) begin
                ptr_q[set_idx] <= (ptr_q[set_idx] == WAY_W'(WAY - 1)) ?
                                  '0 : ptr_q[set_idx] + 1'b1;
            end
        end

        always_comb victim = ptr_q[set_idx];
    end else begin : g_lru
        logic [WAY_W-1:0] age_q [SET][WAY];
        logic [WAY_W-1:0] acc_age;

        assign acc_age = age_q[set_idx][acc_way];

        // Descending scans so the lowest index wins; invalid ways beat age.
        always_comb begin
            victim = '0;
            for (int w = WAY - 1; w >= 0; w--) begin
                if (age_q[set_idx][w] == WAY_W'(WAY - 1)) victim = WAY_W'(w);
            end
            for (int w = WAY - 1; w >= 0; w--) begin
                if (!valid_vec[w]) victim = WAY_W'(w);
            end
        end

        always_ff @(posedge clk) begin
            if (rst || flush_en) begin
                for (int s = 0; s < SET; s++) begin
                    for (int w = 0; w < WAY; w++) age_q[s][w] <= WAY_W'(w);
                end
            end else if (hit_en || fill_en) begin
                for (int w = 0; w < WAY; w++) begin
                    if (WAY_W'(w) == acc_way) begin
                        age_q[set_idx][w] <= '0;
                    end else if (age_q[set_idx][w] < acc_age) begin
                        age_q[set_idx][w] <= age_q[set_idx][w] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/cache_sim_engine.sv
// Single-request cache hit/miss simulator with tag store, FSM and
// saturating statistics; replacement lives in cache_repl_policy.
module cache_sim_engine
    import cache_sim_pkg::*;
#(
    parameter int WAY             = 4,
    parameter int BLOCK_SIZE_BYTE = 16,
    parameter int CACHE_SIZE_BYTE = 1024,
    parameter int ADDR_W          = 32,
    parameter int POLICY          = 0,
    parameter int MISS_LATENCY    = 8,
    parameter int COUNT_W         = 32,
    localparam int SET   = CACHE_SIZE_BYTE / (BLOCK_SIZE_BYTE * WAY),
    localparam int WAY_W = way_w_f(WAY),
    localparam int OFF_W = log2_f(BLOCK_SIZE_BYTE),
    localparam int IDX_W = log2_f(SET),
    localparam int TAG_W = tag_w_f(ADDR_W, SET, BLOCK_SIZE_BYTE)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic               flush,
    output logic               resp_valid,
    output logic               resp_hit,
    output logic [WAY_W-1:0]   resp_way,
    output logic [15:0]        resp_latency,
    output logic [COUNT_W-1:0] hit_count,
    output logic [COUNT_W-1:0] miss_count,
    output logic [COUNT_W-1:0] evict_count
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [TAG_W-1:0]  tag_q [SET][WAY];
    logic [WAY-1:0]    valid_q [SET];
    logic [15:0]       fill_cnt_q;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              accept, flush_en, hit, hit_en, fill_en;
    logic [WAY_W-1:0]  hit_way, victim, acc_way;
    logic              unused_off;

    assign idx        = addr_q[OFF_W +: IDX_W];
    assign tag        = addr_q[ADDR_W-1 -: TAG_W];
    assign unused_off = ^addr_q[OFF_W-1:0];

    assign req_ready  = (state_q == S_IDLE) && !flush;
    assign accept     = req_valid && req_ready;
    assign flush_en   = (state_q == S_IDLE) && flush;
    assign hit_en     = (state_q == S_LOOKUP) && hit;
    assign fill_en    = (state_q == S_UPDATE);
    assign acc_way    = fill_en ? victim : hit_way;
    assign resp_valid = (state_q == S_RESP);

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = WAY - 1; w >= 0; w--) begin
            if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (accept) state_d = S_LOOKUP;
            S_LOOKUP: state_d = hit ? S_RESP : S_FILL;
            S_FILL:   if (fill_cnt_q == 16'(MISS_LATENCY - 1)) state_d = S_UPDATE;
            S_UPDATE: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            fill_cnt_q   <= '0;
            resp_hit     <= 1'b0;
            resp_way     <= '0;
            resp_latency <= '0;
            hit_count    <= '0;
            miss_count   <= '0;
            evict_count  <= '0;
            for (int s = 0; s < SET; s++) valid_q[s] <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= (state_q == S_FILL) ? fill_cnt_q + 1'b1 : '0;
            if (accept) addr_q <= req_addr;
            if (flush_en) begin
                for (int s = 0; s < SET; s++) valid_q[s] <= '0;
            end
            if (hit_en) begin
                resp_hit     <= 1'b1;
                resp_way     <= hit_way;
                resp_latency <= 16'd2;
                if (hit_count != '1) hit_count <= hit_count + 1'b1;
            end
            if ((state_q == S_LOOKUP) && !hit && (miss_count != '1)) begin
                miss_count <= miss_count + 1'b1;
            end
            if (fill_en) begin
                valid_q[idx][victim] <= 1'b1;
                resp_hit             <= 1'b0;
                resp_way             <= victim;
                resp_latency         <= 16'(MISS_LATENCY + 3);
                if (valid_q[idx][victim] && (evict_count != '1)) begin
                    evict_count <= evict_count + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) tag_q[idx][victim] <= tag;
    end

    cache_repl_policy #(
        .WAY    (WAY),
        .SET    (SET),
        .POLICY (POLICY)
    ) u_repl (
        .clk       (clk),
        .rst       (rst),
        .flush_en  (flush_en),
        .set_idx   (idx),
        .valid_vec (valid_q[idx]),
        .hit_en    (hit_en),
        .fill_en   (fill_en),
        .acc_way   (acc_way),
        .victim    (victim)
    );

endmodule

// File: tb/tb_cache_sim_engine.sv
// Bench for cache_sim_engine: LRU, FIFO and 4-bit-counter instances
// share one stimulus stream; responses are checked against a scoreboard.
module tb_cache_sim_engine;

    localparam int ML = 8;

    typedef struct {
        bit hit;
        int way;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] req_addr = '0;

    logic        l_ready, l_rv, l_hit;
    logic [1:0]  l_way;
    logic [15:0] l_lat;
    logic [31:0] l_hc, l_mc, l_ec;
    logic        f_ready, f_rv, f_hit;
    logic [1:0]  f_way;
    logic [15:0] f_lat;
    logic [31:0] f_hc, f_mc, f_ec;
    logic        s_ready, s_rv, s_hit;
    logic [1:0]  s_way;
    logic [15:0] s_lat;
    logic [3:0]  s_hc, s_mc, s_ec;

    exp_t l_q[$];
    exp_t f_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   l_cyc, f_cyc;
    bit   l_acc, f_acc;

    always #5 clk = ~clk;

    cache_sim_engine #(.POLICY(0)) u_lru (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(l_ready),
        .req_addr(req_addr), .flush(flush), .resp_valid(l_rv),
        .resp_hit(l_hit), .resp_way(l_way), .resp_latency(l_lat),
        .hit_count(l_hc), .miss_count(l_mc), .evict_count(l_ec)
    );

    cache_sim_engine #(.POLICY(1)) u_fifo (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(f_ready),
        .req_addr(req_addr), .flush(flush), .resp_valid(f_rv),
        .resp_hit(f_hit), .resp_way(f_way), .resp_latency(f_lat),
        .hit_count(f_hc), .miss_count(f_mc), .evict_count(f_ec)
    );

    cache_sim_engine #(.POLICY(0), .COUNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_ready),
        .req_addr(req_addr), .flush(flush), .resp_valid(s_rv),
        .resp_hit(s_hit), .resp_way(s_way), .resp_latency(s_lat),
        .hit_count(s_hc), .miss_count(s_mc), .evict_count(s_ec)
    );

    // Scoreboard monitors: latency is measured from the accept edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            l_cyc = 0;
            l_acc = 1'b0;
        end else begin
            if (l_acc) l_cyc = 1;
            else if (l_cyc != 0) l_cyc++;
            l_acc = req_valid && l_ready;
            if (l_rv) begin
                n_chk++;
                if (l_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL lru_unexpected_resp: got response, required none");
                end else begin
                    e = l_q.pop_front();
                    n_chk++;
                    if (l_hit !== e.hit) begin
                        n_fail++;
                        $display("FAIL lru_hit: got %0b, required %0b", l_hit, e.hit);
                    end
                    n_chk++;
                    if (l_way !== 2'(e.way)) begin
                        n_fail++;
                        $display("FAIL lru_way: got %0d, required %0d", l_way, e.way);
                    end
                    n_chk++;
                    if (l_lat !== (e.hit ? 16'd2 : 16'(ML + 3))) begin
                        n_fail++;
                        $display("FAIL lru_latency: got %0d, required %0d", l_lat, e.hit ? 2 : ML + 3);
                    end
                    n_chk++;
                    if (l_cyc != (e.hit ? 2 : ML + 3)) begin
                        n_fail++;
                        $display("FAIL lru_cycles: got %0d, required %0d", l_cyc, e.hit ? 2 : ML + 3);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            f_cyc = 0;
            f_acc = 1'b0;
        end else begin
            if (f_acc) f_cyc = 1;
            else if (f_cyc != 0) f_cyc++;
            f_acc = req_valid && f_ready;
            if (f_rv) begin
                n_chk++;
                if (f_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL fifo_unexpected_resp: got response, required none");
                end else begin
                    e = f_q.pop_front();
                    n_chk++;
                    if (f_hit !== e.hit) begin
                        n_fail++;
                        $display("FAIL fifo_hit: got %0b, required %0b", f_hit, e.hit);
                    end
                    n_chk++;
                    if (f_way !== 2'(e.way)) begin
                        n_fail++;
                        $display("FAIL fifo_way: got %0d, required %0d", f_way, e.way);
                    end
                    n_chk++;
                    if (f_lat !== (e.hit ? 16'd2 : 16'(ML + 3))) begin
                        n_fail++;
                        $display("FAIL fifo_latency: got %0d, required %0d", f_lat, e.hit ? 2 : ML + 3);
                    end
                    n_chk++;
                    if (f_cyc != (e.hit ? 2 : ML + 3)) begin
                        n_fail++;
                        $display("FAIL fifo_cycles: got %0d, required %0d", f_cyc, e.hit ? 2 : ML + 3);
                    end
                end
            end
        end
    end

    task automatic push(input bit lh, input int lw, input bit fh, input int fw);
        exp_t e;
        e.hit = lh;
        e.way = lw;
        l_q.push_back(e);
        e.hit = fh;
        e.way = fw;
        f_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send(input logic [31:0] a, input bit flush_mid);
        n_chk++;
        if (!(l_ready && f_ready && s_ready)) begin
            n_fail++;
            $display("FAIL send_ready: got %0b%0b%0b, required 111", l_ready, f_ready, s_ready);
        end
        req_addr  = a;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 0; c < 64; c++) begin
            if (l_ready && f_ready && s_ready) break;
            flush = flush_mid && (c == 3);
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
        n_chk++;
        if (!(l_ready && f_ready && s_ready)) begin
            n_fail++;
            $display("FAIL send_timeout: got not idle after 64 cycles, required idle");
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if (l_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %0b, required 1", l_ready);
        end
        n_chk++;
        if ({l_rv, l_hit, l_way} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_resp: got %0b%0b%0d, required 000", l_rv, l_hit, l_way);
        end
        n_chk++;
        if (l_lat !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_latency: got %0d, required 0", l_lat);
        end
        n_chk++;
        if ({l_hc, l_mc, l_ec} !== 96'd0) begin
            n_fail++;
            $display("FAIL reset_counts: got %0d/%0d/%0d, required 0/0/0", l_hc, l_mc, l_ec);
        end
    endtask

    task automatic test_basic();
        do_reset();
        push(0, 0, 0, 0);
        send(32'h100, 0);
        n_chk++;
        if (l_mc !== 32'd1) begin
            n_fail++;
            $display("FAIL basic_miss_count: got %0d, required 1", l_mc);
        end
        push(1, 0, 1, 0);
        send(32'h104, 0);
        n_chk++;
        if (l_hc !== 32'd1 || l_ec !== 32'd0) begin
            n_fail++;
            $display("FAIL basic_counts: got hit %0d evict %0d, required 1 0", l_hc, l_ec);
        end
    endtask

    task automatic test_repl();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(0, i, 0, i);
            send(32'(i) << 8, 0);
        end
        push(1, 0, 1, 0);
        send(32'h000, 0);
        push(0, 1, 0, 0);
        send(32'h400, 0);
        n_chk++;
        if (l_ec !== 32'd1 || f_ec !== 32'd1) begin
            n_fail++;
            $display("FAIL repl_evict: got lru %0d fifo %0d, required 1 1", l_ec, f_ec);
        end
        push(1, 0, 0, 1);
        send(32'h000, 0);
        n_chk++;
        if (l_hc !== 32'd2 || l_mc !== 32'd5) begin
            n_fail++;
            $display("FAIL repl_lru_counts: got %0d/%0d, required 2/5", l_hc, l_mc);
        end
        n_chk++;
        if (f_hc !== 32'd1 || f_mc !== 32'd6 || f_ec !== 32'd2) begin
            n_fail++;
            $display("FAIL repl_fifo_counts: got %0d/%0d/%0d, required 1/6/2", f_hc, f_mc, f_ec);
        end
    endtask

    task automatic test_flush();
        do_reset();
        push(0, 0, 0, 0);
        send(32'h000, 0);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h000;
        #1;
        n_chk++;
        if (l_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ready: got %0b, required 0", l_ready);
        end
        @(posedge clk);
        #1 flush = 1'b0;
        req_valid = 1'b0;
        #1;
        n_chk++;
        if (l_ready !== 1'b1 || f_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_not_accepted: got %0b%0b, required 11", l_ready, f_ready);
        end
        push(0, 0, 0, 0);
        send(32'h000, 0);
        n_chk++;
        if (l_mc !== 32'd2 || l_ec !== 32'd0) begin
            n_fail++;
            $display("FAIL flush_counts: got miss %0d evict %0d, required 2 0", l_mc, l_ec);
        end
        push(0, 0, 0, 0);
        send(32'h010, 1);
        push(1, 0, 1, 0);
        send(32'h010, 0);
        push(1, 0, 1, 0);
        send(32'h000, 0);
        n_chk++;
        if (l_hc !== 32'd2 || l_mc !== 32'd3) begin
            n_fail++;
            $display("FAIL flush_busy_ignored: got %0d/%0d, required 2/3", l_hc, l_mc);
        end
    endtask

    task automatic test_rst_fill();
        do_reset();
        req_addr  = 32'h000;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (l_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_fill_busy: got %0b, required 0", l_ready);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        n_chk++;
        if (l_ready !== 1'b1 || l_rv !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_fill_state: got ready %0b valid %0b, required 1 0", l_ready, l_rv);
        end
        n_chk++;
        if ({l_hc, l_mc, l_ec} !== 96'd0) begin
            n_fail++;
            $display("FAIL rst_fill_counts: got %0d/%0d/%0d, required 0/0/0", l_hc, l_mc, l_ec);
        end
        repeat (12) @(posedge clk);
        #1;
        push(0, 0, 0, 0);
        send(32'h000, 0);
        n_chk++;
        if (l_mc !== 32'd1) begin
            n_fail++;
            $display("FAIL rst_fill_miss: got %0d, required 1", l_mc);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        push(0, 0, 0, 0);
        send(32'h000, 0);
        for (int i = 0; i < 20; i++) begin
            push(1, 0, 1, 0);
            send(32'h000, 0);
            if (i == 14) begin
                n_chk++;
                if (s_hc !== 4'd15) begin
                    n_fail++;
                    $display("FAIL sat_reach: got %0d, required 15", s_hc);
                end
            end
        end
        n_chk++;
        if (s_hc !== 4'd15 || s_mc !== 4'd1) begin
            n_fail++;
            $display("FAIL sat_hold: got hit %0d miss %0d, required 15 1", s_hc, s_mc);
        end
        n_chk++;
        if (l_hc !== 32'd20) begin
            n_fail++;
            $display("FAIL sat_wide: got %0d, required 20", l_hc);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish by 300000, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_repl();
        test_flush();
        test_rst_fill();
        test_saturate();
        repeat (4) @(posedge clk);
        n_chk++;
        if (l_q.size() != 0 || f_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_resp: got %0d/%0d pending, required 0/0", l_q.size(), f_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_sim_engine.md
CACHE_SIM_ENGINE -- requirements
Module: cache_sim_engine

Interface
REQ-001 Param WAY, default 4, associativity (power of 2, 1..16).
REQ-002 Param BLOCK_SIZE_BYTE, default 16, line size (power of 2, >=4).
REQ-003 Param CACHE_SIZE_BYTE, default 1024, capacity; SET = CACHE_SIZE_BYTE/(BLOCK_SIZE_BYTE*WAY), power of 2, >=2.
REQ-004 Param ADDR_W, default 32, request address width.
REQ-005 Param POLICY, default 0, replacement: 0 = LRU, 1 = FIFO.
REQ-006 Param MISS_LATENCY, default 8, fill wait cycles (>=1).
REQ-007 Param COUNT_W, default 32, statistics counter width.
REQ-008 clk  in  1  sole clock; all logic on rising edge.
REQ-009 rst  in  1  synchronous, active-high reset.
REQ-010 req_valid  in  1  address request present.
REQ-011 req_ready  out  1  engine can accept a request.
REQ-012 req_addr  in  ADDR_W  byte address; split offset/index/tag as {tag, index[log2 SET], offset[log2 BLOCK_SIZE_BYTE]}.
REQ-013 flush  in  1  invalidate all lines.
REQ-014 resp_valid  out  1  one-cycle response pulse, no backpressure.
REQ-015 resp_hit  out  1  1 = hit, 0 = miss.
REQ-016 resp_way  out  max(1,log2 WAY)  way hit or filled.
REQ-017 resp_latency  out  16  cycles from accept edge to resp_valid.
REQ-018 hit_count, miss_count, evict_count  out  COUNT_W each  statistics.

Function
REQ-019 FSM states IDLE, LOOKUP, FILL, UPDATE, RESP; req_ready = 1 only in IDLE with flush = 0.
REQ-020 Accept on req_valid & req_ready edge (cycle 0); address latched; LOOKUP in cycle 1 compares all WAY tags/valid bits of the indexed set.
REQ-021 Hit: RESP in cycle 2, resp_valid=1, resp_hit=1, resp_latency=2, replacement state updated, hit_count+1.
REQ-022 Miss: FILL for exactly MISS_LATENCY cycles, UPDATE writes tag/valid to victim, RESP at cycle MISS_LATENCY+3, resp_latency=MISS_LATENCY+3, miss_count+1.
REQ-023 Return to IDLE the cycle after RESP; at most one request in flight.
REQ-024 LRU: victim = lowest-index invalid way, else way with max age; on hit/fill accessed way age=0, ways with age below its old age +1; ages remain a permutation of 0..WAY-1.
REQ-025 FIFO: victim = per-set pointer way, pointer increments mod WAY on every fill; hits leave pointer unchanged.
REQ-026 evict_count+1 when the victim line was valid at UPDATE.
REQ-027 All counters saturate at all-ones; no wrap.
REQ-028 flush honoured only in IDLE: one cycle, clears every valid bit, ages to way index, FIFO pointers to 0; counters untouched; flush with req_valid same cycle -> flush wins, request not accepted.
REQ-029 flush outside IDLE ignored (not queued).
REQ-030 resp_hit, resp_way, resp_latency hold last response value when resp_valid=0.

Reset
REQ-031 rst: state IDLE, all valid bits 0, age[w]=w, FIFO pointers 0, all counters 0, resp_valid 0, resp_hit 0, resp_way 0, resp_latency 0.
REQ-032 rst in any state (incl. FILL) aborts the in-flight request; no response emitted, req_ready=1 the cycle after rst deasserts.

Structure
REQ-033 Package cache_sim_pkg holds state enum, policy constants (LRU/FIFO), and log2 derivation helpers for offset/index/tag widths.
REQ-034 Sub-module cache_repl_policy holds per-set age/pointer storage, victim selection and update; engine holds tag/valid arrays, FSM, counters.

Verification (WAY=4, BLOCK=16, CACHE=1024, MISS_LATENCY=8; SET=16, index=addr[7:4])
REQ-035 Reset, read 0x100 -> miss, resp_latency=11, miss_count=1; read 0x104 -> hit, resp_latency=2, hit_count=1.
REQ-036 LRU: 0x000,0x100,0x200,0x300 then 0x000 (hit), 0x400 -> miss into way 1, evict_count=1; 0x000 -> hit, resp_way=0.
REQ-037 FIFO: same sequence -> 0x400 fills way 0, evict_count=1; next 0x000 -> miss.
REQ-038 Fill 0x000, flush with req_valid high -> request not accepted that cycle; then 0x000 -> miss; counters not cleared by flush.
REQ-039 rst during FILL cycle 3 -> no resp_valid, all counters 0, req_ready=1 next cycle, 0x000 -> miss.
REQ-040 COUNT_W=4: 20 hits to 0x000 -> hit_count=15, stays 15.
